// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Imported by the fetch buffer and the fetch top level.
package riscv_fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, word} entries.
// Flush beats push and pop; head is the oldest entry.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-deep request pipe, buffer to decode.
// Redirects flush; misaligned targets park the unit in FAULT.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic [31:0] mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be 4-byte aligned");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of two >= 2");
  end

  fetch_state_t  state_q;
  logic          fault_q;
  logic [31:0]   fault_pc_q;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  fetch_entry_t  hold_q, hold_d;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          pop, push, issue, misaligned;

  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign inst_valid = (fifo_count != '0) && (state_q == RUN);
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_q & ~redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, data: mem_data_out};

  // slots already promised: buffered + in flight, minus the one leaving
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q)
                     - (CW+1)'(pop);
  assign issue = (state_q == RUN) && !redirect_valid
              && (credit_used < (CW+1)'(FIFO_DEPTH));

  // PC advance, request tracking and last-delivered hold value
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    hold_d        = inst_valid ? fifo_head : hold_q;
    if (redirect_valid) begin
      if (!misaligned) pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + 32'(INSTR_BYTES);
      inflight_pc_d = pc_q;
    end
  end

  // datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_q        <= hold_d;
    end
  end

  // RUN/FAULT control with registered fault outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect_valid) begin
      if (misaligned) begin
        state_q    <= FAULT;
        fault_q    <= 1'b1;
        fault_pc_q <= redirect_pc;
      end else begin
        state_q <= RUN;
        fault_q <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign mem_address    = pc_q;
  assign mem_read_write = '0;
  assign mem_data_in    = '0;
  assign inst_pc        = inst_valid ? fifo_head.pc : hold_q.pc;
  assign inst_data      = inst_valid ? fifo_head.data : hold_q.data;
  assign fetch_fault    = fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the five-stage RISC-V core; it is the requesting side of the instruction memory's byte-addressed, little-endian 32-bit read port.
- Holds the PC and issues one word read per cycle at 1-cycle memory read latency.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush and discard of in-flight data) and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0100_0000, first fetch address after reset; must be 4-byte aligned (elaboration-time check).
- FIFO_DEPTH, 2, instruction buffer entries; minimum 2, power of two.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_address  output  32  byte address to the instruction memory.
- mem_read_write  output  32  always 0 (read); this block never writes.
- mem_data_in  output  32  always 0.
- mem_data_out  input  32  memory read data, valid 1 cycle after the address is issued.
- redirect_valid  input  1  one-cycle pulse: load PC from redirect_pc.
- redirect_pc  input  32  redirect target.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decode accepts the head.
- inst_pc  output  32  PC of the head entry.
- inst_data  output  32  instruction word of the head entry.
- fetch_fault  output  1  sticky misaligned-target fault.
- fault_pc  output  32  offending target address.

Behaviour:
- Reset values:
  - pc_q = RESET_PC; mem_address = RESET_PC.
  - FIFO empty; inflight = 0; state = RUN.
  - inst_valid = 0, inst_pc = 0, inst_data = 0.
  - fetch_fault = 0, fault_pc = 0.
  - Reset mid-operation drops everything immediately.
- mem_address is always driven from pc_q. An internal issue flag marks real requests.
- pop = inst_valid & inst_ready.
- issue is asserted when all of the following hold:
  - state == RUN;
  - redirect_valid == 0;
  - fifo_count + inflight − pop < FIFO_DEPTH.
- On issue:
  - pc_q <= pc_q + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - inflight <= 1; inflight_pc <= pc_q.
  - With no issue, inflight <= 0.
- Response: when inflight == 1 and no redirect this cycle, push {inflight_pc, mem_data_out} into the FIFO. The entry is visible on inst_valid the next cycle.
- Latency and throughput:
  - Address at cycle t, data on mem_data_out at t+1, inst_valid at t+2.
  - Sustained 1 instruction/cycle with inst_ready held high.
- Push and pop in the same cycle are allowed. The credit rule guarantees no overflow.
- FIFO empty: inst_valid = 0; inst_pc and inst_data hold their last values.
- Redirect with redirect_pc[1:0] == 0:
  - FIFO flushed, in-flight response discarded, pc_q <= redirect_pc.
  - No issue that cycle; the first issue of the target is on the next cycle.
  - Redirect wins over a simultaneous pop and push; the popped entry counts as consumed.
- Redirect with redirect_pc[1:0] != 0:
  - Same flush and discard.
  - state <= FAULT; fetch_fault <= 1; fault_pc <= redirect_pc; pc_q unchanged.
- FSM:
  - RUN -> FAULT on a misaligned redirect.
  - FAULT -> RUN on an aligned redirect (clears fetch_fault and loads pc_q).
  - FAULT -> FAULT on a further misaligned redirect (updates fault_pc).
  - In FAULT: no issue, inst_valid = 0.
- Back-to-back redirects: the last one wins. Each redirect flushes again.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch_state_t {RUN, FAULT};
  - INSTR_BYTES = 4;
  - fetch_entry_t {pc[31:0], data[31:0]};
  - RESET_PC_DEFAULT.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush and count.
  - flush has priority over push and pop.

Test Plan:
- Reset release, inst_ready=1, memory returns word = address:
  - mem_address sequence 0x01000000, 0x01000004, …;
  - first inst_valid 2 cycles after reset with inst_pc=0x01000000, inst_data=0x01000000;
  - then one instruction per cycle.
- inst_ready=0 for 6 cycles:
  - issues stop once the FIFO holds 2 entries plus no inflight;
  - on release, PCs continue in order with no duplicate or gap.
- Redirect to 0x01000100 while the FIFO is full and a response is inflight:
  - next inst_valid is 0 for two cycles;
  - then inst_pc=0x01000100; no stale PC ever appears.
- Redirect to 0x01000102:
  - fetch_fault=1, fault_pc=0x01000102, inst_valid stays 0, no issues;
  - a later redirect to 0x01000200 clears the fault and resumes at 0x01000200.
- Redirect to 0xFFFFFFF8:
  - delivered PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert reset_n low while the FIFO is full:
  - outputs return to reset values immediately;
  - after release, fetch restarts at 0x01000000.
